// File: rtl/clk_stepping_mc.sv
// Multi-channel clock-stepping controller: each channel runs N gated cycles
// (one-shot or repeating with P-cycle gaps) or passes clk_i straight through.

// Latch-based clock gate equivalent to tc_clk_gating, with an asynchronous clear
// so the gated clock drops as soon as reset asserts.
module clk_stepping_mc_gate (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_latch;

    always_latch begin
        if (!rst_ni) begin
            en_latch <= 1'b0;
        end else if (!clk_i) begin
            en_latch <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;
endmodule

module clk_stepping_mc #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          en_i,
    input  logic [2*NUM_CH-1:0]        mode_i,
    input  logic [CNT_W*NUM_CH-1:0]    cycles_i,
    input  logic [CNT_W*NUM_CH-1:0]    pause_i,
    input  logic [NUM_CH-1:0]          start_i,
    input  logic [NUM_CH-1:0]          abort_i,
    output logic [NUM_CH-1:0]          clk_o,
    output logic [NUM_CH-1:0]          clk_en_o,
    output logic [NUM_CH-1:0]          running_o,
    output logic [NUM_CH-1:0]          done_o,
    output logic [CNT_W*NUM_CH-1:0]    cycles_left_o,
    output logic [BURST_W*NUM_CH-1:0]  bursts_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_e             state_q;
        logic               repeat_q;
        logic [CNT_W-1:0]   cnt_q;
        logic [CNT_W-1:0]   pcnt_q;
        logic [BURST_W-1:0] bursts_q;
        logic               done_q;
        logic               clk_en_q;

        logic [1:0]         mode_c;
        logic [CNT_W-1:0]   cycles_c;
        logic [CNT_W-1:0]   pause_c;
        logic               bypass;
        logic               bursts_max;

        assign mode_c     = mode_i[2*gi +: 2];
        assign cycles_c   = cycles_i[CNT_W*gi +: CNT_W];
        assign pause_c    = pause_i[CNT_W*gi +: CNT_W];
        assign bursts_max = &bursts_q;
        // Mode is latched at start, so mode_i only selects bypass while idle.
        assign bypass = !en_i[gi] ||
                        (((state_q == S_IDLE) || (state_q == S_DONE)) &&
                         ((mode_c == 2'b00) || (mode_c == 2'b11)));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= S_IDLE;
                repeat_q <= 1'b0;
                cnt_q    <= '0;
                pcnt_q   <= '0;
                bursts_q <= '0;
                done_q   <= 1'b0;
                clk_en_q <= 1'b0;
            end else begin
                done_q   <= 1'b0;
                clk_en_q <= 1'b0;
                if (bypass) begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    pcnt_q   <= '0;
                    clk_en_q <= 1'b1;
                end else begin
                    case (state_q)
                        S_IDLE, S_DONE: begin
                            if (start_i[gi]) begin
                                repeat_q <= (mode_c == 2'b10);
                                if (cycles_c == '0) begin
                                    state_q  <= S_DONE;
                                    done_q   <= 1'b1;
                                    bursts_q <= BURST_W'(1);
                                    cnt_q    <= '0;
                                end else begin
                                    state_q  <= S_RUN;
                                    cnt_q    <= cycles_c;
                                    bursts_q <= '0;
                                    clk_en_q <= 1'b1;
                                end
                            end
                        end
                        S_RUN: begin
                            if (abort_i[gi]) begin
                                state_q <= S_DONE;
                                cnt_q   <= '0;
                                pcnt_q  <= '0;
                            end else if (cnt_q == CNT_W'(1)) begin
                                done_q <= 1'b1;
                                cnt_q  <= '0;
                                if (!bursts_max) begin
                                    bursts_q <= bursts_q + BURST_W'(1);
                                end
                                if (!repeat_q) begin
                                    state_q <= S_DONE;
                                end else if (pause_c != '0) begin
                                    state_q <= S_PAUSE;
                                    pcnt_q  <= pause_c;
                                end else if (cycles_c != '0) begin
                                    cnt_q    <= cycles_c;
                                    clk_en_q <= 1'b1;
                                end else begin
                                    state_q <= S_DONE;
                                end
                            end else begin
                                cnt_q    <= cnt_q - CNT_W'(1);
                                clk_en_q <= 1'b1;
                            end
                        end
                        S_PAUSE: begin
                            if (abort_i[gi]) begin
                                state_q <= S_DONE;
                                cnt_q   <= '0;
                                pcnt_q  <= '0;
                            end else if (pcnt_q == CNT_W'(1)) begin
                                pcnt_q <= '0;
                                // A zero run length on reload counts as an immediate completion.
                                if (cycles_c == '0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                    if (!bursts_max) begin
                                        bursts_q <= bursts_q + BURST_W'(1);
                                    end
                                end else begin
                                    state_q  <= S_RUN;
                                    cnt_q    <= cycles_c;
                                    clk_en_q <= 1'b1;
                                end
                            end else begin
                                pcnt_q <= pcnt_q - CNT_W'(1);
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end

        assign clk_en_o[gi]                        = clk_en_q;
        assign running_o[gi]                       = (state_q == S_RUN);
        assign done_o[gi]                          = done_q;
        assign cycles_left_o[CNT_W*gi +: CNT_W]    = cnt_q;
        assign bursts_o[BURST_W*gi +: BURST_W]     = bursts_q;

        clk_stepping_mc_gate u_gate (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .en_i      (clk_en_q),
            .test_en_i (1'b0),
            .clk_o     (clk_o[gi])
        );
    end
endmodule
